alu_arbiter: RTL

Shares the single 4-bit combinational `alu` datapath between two requesters. It arbitrates round-robin, captures the winner's operands and opcode, and drives the ALU for one cycle. It then registers the ALU result and returns it on a valid/ready response channel tagged with the requester ID. It sits between the two operand sources (requester 0 and requester 1) and the `alu` instance, which is external to this block.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external 4-bit ALU between two requesters
// and returns the registered result on a valid/ready response channel.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_a0,
  input  logic [3:0]  req_b0,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_a1,
  input  logic [3:0]  req_b1,
  input  logic [3:0]  req_op1,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_x,
  input  logic [31:0] alu_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_x,
  output logic [31:0] rsp_y,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic        legal;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic [3:0]  sel_op;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic [3:0]  op_code;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && (|req_valid) && !rst;
  assign sel_a  = grant ? req_a1  : req_a0;
  assign sel_b  = grant ? req_b1  : req_b0;
  assign sel_op = grant ? req_op1 : req_op0;

  always_comb begin
    legal = 1'b0;
    case (sel_op)
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1010, 4'b1011, 4'b1101, 4'b1110: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = legal ? EXEC : RESP;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant] = 1'b1;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Operand registers load only for legal ops, so an illegal op leaves the ALU inputs untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_err    <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        rsp_id     <= grant;
        if (legal) begin
          op_a    <= sel_a;
          op_b    <= sel_b;
          op_code <= sel_op;
        end else begin
          rsp_x   <= '0;
          rsp_y   <= '0;
          rsp_err <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rsp_x   <= alu_x;
        rsp_y   <= alu_y;
        rsp_err <= 1'b0;
      end
      if (state == RESP && rsp_ready && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
    end
  end

  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;

endmodule
